mu0_control: RTL

- Control unit for the MU0 datapath. It generates the load enables that the 16-bit datapath registers (ACC, PC, IR) consume, plus mux selects, ALU function and memory strobes.
- Implements the two-phase fetch/execute sequence with a halt state.
- Keeps a count of retired instructions.
- Sits beside the datapath in the MU0 top level. It is the initiator side of the register enable interface.

---
 rtl/mu0_pkg.sv | 44 ++++
 rtl/mu0_decode.sv | 57 +++++
 rtl/mu0_control.sv | 99 +++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// MU0 shared definitions: opcodes, ALU function codes,
// operand selects, FSM states and the control bundle.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] FS_PASSY = 2'b00;
    localparam logic [1:0] FS_ADD   = 2'b01;
    localparam logic [1:0] FS_SUB   = 2'b10;
    localparam logic [1:0] FS_INC   = 2'b11;

    localparam logic SEL_ACC = 1'b0;
    localparam logic SEL_PC  = 1'b1;
    localparam logic SEL_MEM = 1'b0;
    localparam logic SEL_IR  = 1'b1;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic       acc_en;
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic [1:0] alu_fs;
        logic       rd;
        logic       wr;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mu0_decode.sv
// MU0 execute-phase decoder: opcode and flags to the
// EXECUTE control vector plus a halt request.
module mu0_decode
    import mu0_pkg::*;
#(
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic [3:0] opcode,
    input  logic       n,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       halt_req
);

    always_comb begin
        ctrl          = CTRL_IDLE;
        ctrl.addr_sel = SEL_IR;
        halt_req      = 1'b0;
        unique case (1'b1)
            (opcode == OP_LDA): begin
                ctrl.rd     = 1'b1;
                ctrl.y_sel  = SEL_MEM;
                ctrl.alu_fs = FS_PASSY;
                ctrl.acc_en = 1'b1;
            end
            (opcode == OP_STA): begin
                ctrl.wr    = 1'b1;
                ctrl.x_sel = SEL_ACC;
            end
            (opcode == OP_ADD),
            (opcode == OP_SUB): begin
                ctrl.rd     = 1'b1;
                ctrl.x_sel  = SEL_ACC;
                ctrl.y_sel  = SEL_MEM;
                ctrl.alu_fs = (opcode == OP_ADD) ? FS_ADD : FS_SUB;
                ctrl.acc_en = 1'b1;
            end
            (opcode == OP_JMP),
            (opcode == OP_JGE),
            (opcode == OP_JNE): begin
                ctrl.addr_sel = 1'b0;
                ctrl.y_sel    = SEL_IR;
                ctrl.alu_fs   = FS_PASSY;
                ctrl.pc_en    = (opcode == OP_JMP) ? 1'b1 :
                                (opcode == OP_JGE) ? ~n : ~z;
            end
            (opcode == OP_STP): begin
                halt_req = 1'b1;
            end
            default: begin
                // opcodes 8-F: no-op, optionally a halt
                halt_req = (HALT_ON_ILLEGAL != 0);
            end
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute/halt FSM, retired
// instruction counter and register enable generation.
module mu0_control
    import mu0_pkg::*;
#(
    parameter int COUNT_WIDTH     = 16,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [3:0]             Opcode,
    input  logic                   N,
    input  logic                   Z,
    output logic                   IR_En,
    output logic                   PC_En,
    output logic                   Acc_En,
    output logic                   X_sel,
    output logic                   Y_sel,
    output logic                   Addr_sel,
    output logic [1:0]             ALU_fs,
    output logic                   Rd,
    output logic                   Wr,
    output logic                   Fetch,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] Instr_Count
);

    state_t state, next;
    ctrl_t  dec_ctrl, ctrl, fetch_ctrl;
    logic   halt_req;
    logic [COUNT_WIDTH-1:0] count;

    mu0_decode #(
        .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
    ) u_decode (
        .opcode  (Opcode),
        .n       (N),
        .z       (Z),
        .ctrl    (dec_ctrl),
        .halt_req(halt_req)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_FETCH;
            count <= '0;
        end else begin
            state <= next;
            if (state == S_EXECUTE)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        next = S_FETCH;
        unique case (state)
            S_FETCH:   next = S_EXECUTE;
            S_EXECUTE: next = halt_req ? S_HALT : S_FETCH;
            S_HALT:    next = S_HALT;
            default:   next = S_FETCH;
        endcase
    end

    always_comb begin
        fetch_ctrl          = CTRL_IDLE;
        fetch_ctrl.addr_sel = 1'b0;
        fetch_ctrl.rd       = 1'b1;
        fetch_ctrl.ir_en    = 1'b1;
        fetch_ctrl.x_sel    = SEL_PC;
        fetch_ctrl.alu_fs   = FS_INC;
        fetch_ctrl.pc_en    = 1'b1;
    end

    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (state)
            S_FETCH:   ctrl = fetch_ctrl;
            S_EXECUTE: ctrl = dec_ctrl;
            default:   ctrl = CTRL_IDLE;
        endcase
        // reset kills strobes at once, even mid-instruction
        if (Reset)
            ctrl = CTRL_IDLE;
    end

    assign IR_En       = ctrl.ir_en;
    assign PC_En       = ctrl.pc_en;
    assign Acc_En      = ctrl.acc_en;
    assign X_sel       = ctrl.x_sel;
    assign Y_sel       = ctrl.y_sel;
    assign Addr_sel    = ctrl.addr_sel;
    assign ALU_fs      = ctrl.alu_fs;
    assign Rd          = ctrl.rd;
    assign Wr          = ctrl.wr;
    assign Fetch       = (state == S_FETCH);
    assign Halted      = (state == S_HALT);
    assign Instr_Count = count;

endmodule
